tdm_demux: RTL
==============

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bits per channel slot.
REQ-002 The block SHALL have parameter CHANNELS, fixed at 4, giving the number of time slots per frame.
REQ-003 Clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 Resetn  input  1  reset, asynchronous and active-low.
REQ-005 sync  input  1  frame-start strobe, sampled on a rising Clock edge.
REQ-006 en  input  1  bit strobe; d SHALL be sampled only in cycles with en=1.
REQ-007 d  input  1  shared serial data line.
REQ-008 q0, q1, q2, q3  output  WIDTH each  demultiplexed channel words, registered.
REQ-009 valid  output  1  one-cycle pulse: q0..q3 hold a new complete frame.
REQ-010 busy  output  1  high while in RECV.
REQ-011 sel  output  2  current slot index (channel being filled).
REQ-012 frame_err  output  1  one-cycle pulse: a frame was aborted.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and RECV.
REQ-014 In IDLE: busy=0 and sel=0; d SHALL be ignored.
REQ-015 In IDLE with sync=1, the next state SHALL be RECV with slot=0 and bitcnt=0; d SHALL not be sampled in the sync cycle.
REQ-016 In RECV with en=1 and sync=0, d SHALL shift into shift register sel, MSB first (shift left, d into bit 0), and bitcnt SHALL increment.
REQ-017 When bitcnt=WIDTH-1 and en=1, bitcnt SHALL wrap to 0 and the slot SHALL advance by 1.
REQ-018 In RECV with en=0 and sync=0, all state SHALL hold.
REQ-019 On the en=1 cycle sampling bit WIDTH-1 of slot 3, the next edge SHALL load q0..q3 simultaneously from the four shift registers, including the final bit.
REQ-020 On that same edge, valid SHALL go to 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-021 Latency: valid and the new q values SHALL appear 1 cycle after the last bit is sampled.
REQ-022 q0..q3 SHALL hold their values until the next complete frame; they SHALL never show partial data.
REQ-023 sync=1 in RECV (including together with en=1, and on the final-bit cycle) SHALL abort the frame.
REQ-024 On an abort: frame_err=1 for one cycle, no valid, q0..q3 unchanged, d not sampled, and reception restarts in RECV at slot 0 / bitcnt 0.
REQ-025 sync=1 on the cycle valid is high (state IDLE) SHALL start a new frame normally, with no frame_err.
REQ-026 valid and frame_err SHALL never both be 1 in the same cycle.
REQ-027 Shift registers SHALL be cleared at each frame start (sync accepted).

Reset
REQ-028 While Resetn=0, independent of Clock: state IDLE, slot=0, bitcnt=0, shift registers=0, q0..q3=0, valid=0, busy=0, sel=0, frame_err=0.
REQ-029 Resetn asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait in IDLE for sync.
REQ-030 The first rising edge after Resetn deasserts SHALL be able to accept sync.

Verification (WIDTH=4)
REQ-031 sync, then 16 consecutive en=1 bits 1010 0011 1111 0000 -> q0=4'hA, q1=4'h3, q2=4'hF, q3=4'h0; valid=1 one cycle after the 16th bit; busy=0 afterwards.
REQ-032 Same frame with en=0 gaps of 1-3 cycles between bits -> identical q values; sel steps 0,1,2,3 only after every 4th en=1 cycle.
REQ-033 sync after 9 bits, then a full frame of 0x1,0x2,0x4,0x8 -> frame_err pulses once; q stays at the previous frame, then becomes 1,2,4,8 with a single valid.
REQ-034 sync together with the 16th bit -> frame_err=1, valid=0, q unchanged, busy=1, sel=0.
REQ-035 Resetn low for 1 cycle after 6 bits -> all outputs 0 at once; bits without sync are ignored; a following full frame decodes correctly.
REQ-036 Back-to-back frames with sync in the valid cycle -> two valid pulses and no frame_err.

Source files
------------

// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: serial input side plus the
// four parallel channel words and status strobes.
interface tdm_demux_if #(
  parameter int WIDTH = 4
);
  logic             sync;
  logic             en;
  logic             d;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q3;
  logic             valid;
  logic             busy;
  logic [1:0]       sel;
  logic             frame_err;

  modport master (
    output sync, en, d,
    input  q0, q1, q2, q3, valid, busy, sel, frame_err
  );

  modport slave (
    input  sync, en, d,
    output q0, q1, q2, q3, valid, busy, sel, frame_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: a sync strobe opens a frame of four
// WIDTH-bit slots, shifted in MSB first, published atomically on q0..q3.
module tdm_demux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  tdm_demux_if.slave  bus
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam int             CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [1:0]     LAST_SLOT = 2'(CHANNELS - 1);

  state_t           state, state_nx;
  logic [1:0]       slot, slot_nx;
  logic [CW-1:0]    bitcnt, bitcnt_nx;
  logic [WIDTH-1:0] shreg    [CHANNELS];
  logic [WIDTH-1:0] shreg_nx [CHANNELS];
  logic [WIDTH-1:0] q        [CHANNELS];
  logic [WIDTH-1:0] q_nx     [CHANNELS];
  logic             valid_r, valid_nx;
  logic             err_r, err_nx;

  // NOTE: the shift registers and output words are reset explicitly; they
  // are small flop arrays, not RAM, and must read as zero during reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      slot    <= '0;
      bitcnt  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shreg[i] <= '0;
        q[i]     <= '0;
      end
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state   <= state_nx;
      slot    <= slot_nx;
      bitcnt  <= bitcnt_nx;
      valid_r <= valid_nx;
      err_r   <= err_nx;
      for (int i = 0; i < CHANNELS; i++) begin
        shreg[i] <= shreg_nx[i];
        q[i]     <= q_nx[i];
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    state_nx  = state;
    slot_nx   = slot;
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    q_nx      = q;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.sync) begin
          state_nx  = RECV;
          slot_nx   = '0;
          bitcnt_nx = '0;
          for (int i = 0; i < CHANNELS; i++) shreg_nx[i] = '0;
        end
      end

      RECV: begin
        if (bus.sync) begin
          // Abort: restart the frame in place; q keeps the last good frame.
          err_nx    = 1'b1;
          slot_nx   = '0;
          bitcnt_nx = '0;
          for (int i = 0; i < CHANNELS; i++) shreg_nx[i] = '0;
        end else if (bus.en) begin
          shreg_nx[slot] = (shreg[slot] << 1) | WIDTH'(bus.d);
          if (bitcnt == LAST_BIT) begin
            bitcnt_nx = '0;
            if (slot == LAST_SLOT) begin
              // Publish from the next-state copy so the final bit is included.
              q_nx     = shreg_nx;
              valid_nx = 1'b1;
              slot_nx  = '0;
              state_nx = IDLE;
            end else begin
              slot_nx = slot + 2'd1;
            end
          end else begin
            bitcnt_nx = bitcnt + CW'(1);
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign bus.q0        = q[0];
  assign bus.q1        = q[1];
  assign bus.q2        = q[2];
  assign bus.q3        = q[3];
  assign bus.valid     = valid_r;
  assign bus.frame_err = err_r;
  assign bus.busy      = (state == RECV);
  assign bus.sel       = (state == RECV) ? slot : 2'd0;

endmodule
